// File: rtl/trinity_tile_v2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trinity_pkg
//  Purpose  : Shared opcode / state encodings and widths for the Trinity v2
//             tile.
//  Revision : 2.0 - second-generation tile with command FSM
// ============================================================================
package trinity_pkg;

    // Command opcodes carried on uii_cmd
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_ADD   = 3'd2,
        OP_STORE = 3'd3,
        OP_FETCH = 3'd4,
        OP_CLR   = 3'd5,
        OP_SEND  = 3'd6,
        OP_RECV  = 3'd7
    } opcode_e;

    // Command FSM states; encoding 3 is unused and treated as IDLE
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_WAIT = 2'd1,
        ST_RECV_WAIT = 2'd2
    } state_e;

    // {state[1:0], carry, rx_full}
    localparam int STATUS_W = 4;

endpackage
`default_nettype wire

// File: rtl/trinity_tile_v2_if.sv
`default_nettype none
// ============================================================================
//  Module   : trinity_tile_v2_if
//  Purpose  : Command port, pad output and neighbour link bundle of the
//             Trinity v2 tile. The tile connects through the slave modport.
//  Revision : 2.0 - second-generation tile with command FSM
// ============================================================================
interface trinity_tile_v2_if #(
    parameter int WIDTH = 8
);
    import trinity_pkg::*;

    // Command port
    logic [WIDTH-1:0]    uii_in;
    logic [2:0]          uii_cmd;
    logic                uii_cmd_valid;
    logic                uii_cmd_ready;
    logic                uii_abort;

    // Pad-side outputs
    logic [WIDTH-1:0]    uii_out;
    logic [STATUS_W-1:0] uii_status;

    // Inbound link
    logic [WIDTH-1:0]    uii_link_in;
    logic                uii_link_in_valid;
    logic                uii_link_in_ready;

    // Outbound link
    logic [WIDTH-1:0]    uii_link_out;
    logic                uii_link_out_valid;
    logic                uii_link_out_ready;
    logic [WIDTH-1:0]    uii_link_oe;

    modport slave (
        input  uii_in, uii_cmd, uii_cmd_valid, uii_abort,
        input  uii_link_in, uii_link_in_valid, uii_link_out_ready,
        output uii_cmd_ready, uii_out, uii_status, uii_link_in_ready,
        output uii_link_out, uii_link_out_valid, uii_link_oe
    );

    modport master (
        output uii_in, uii_cmd, uii_cmd_valid, uii_abort,
        output uii_link_in, uii_link_in_valid, uii_link_out_ready,
        input  uii_cmd_ready, uii_out, uii_status, uii_link_in_ready,
        input  uii_link_out, uii_link_out_valid, uii_link_oe
    );

endinterface
`default_nettype wire

// File: rtl/trinity_rx_buf.sv
`default_nettype none
// ============================================================================
//  Module   : trinity_rx_buf
//  Purpose  : One-entry inbound link holding register. Captures a word when
//             offered while empty; the consumer clears it. No bypass path.
//  Revision : 2.0 - second-generation tile with command FSM
// ============================================================================
module trinity_rx_buf #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_capture,
    input  wire logic             i_consume,
    output logic                  o_full,
    output logic [WIDTH-1:0]      o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Consume only while full and capture only while empty, so the two never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_consume && r_full) begin
            r_full <= 1'b0;
        end else if (i_capture && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/trinity_tile_v2.sv
`default_nettype none
// ============================================================================
//  Module   : trinity_tile_v2
//  Purpose  : Single-issue accumulator tile: WIDTH-bit accumulator with carry,
//             DEPTH-entry local memory, and valid/ready neighbour link driven
//             by a small command FSM.
//  Revision : 2.0 - second-generation tile with command FSM
// ============================================================================
module trinity_tile_v2
    import trinity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst_n,
    trinity_tile_v2_if.slave bus
);

    localparam int         c_AW           = $clog2(DEPTH);
    localparam logic [1:0] c_ST_IDLE      = ST_IDLE;
    localparam logic [1:0] c_ST_SEND_WAIT = ST_SEND_WAIT;
    localparam logic [1:0] c_ST_RECV_WAIT = ST_RECV_WAIT;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_rx_full;
    logic [WIDTH-1:0] w_rx_data;
    logic             w_idle;
    logic             w_sending;
    logic             w_accept;
    logic             w_consume;
    opcode_e          w_op;
    logic [c_AW-1:0]  w_addr;
    logic [WIDTH:0]   w_sum;

    // Anything that is not a wait state (including the unused code) behaves as IDLE
    assign w_idle    = (r_state != c_ST_SEND_WAIT) && (r_state != c_ST_RECV_WAIT);
    assign w_sending = (r_state == c_ST_SEND_WAIT);
    assign w_op      = opcode_e'(bus.uii_cmd);
    assign w_accept  = bus.uii_cmd_valid && w_idle;
    assign w_addr    = bus.uii_in[c_AW-1:0];
    assign w_sum     = {1'b0, r_acc} + {1'b0, bus.uii_in};

    // Abort in RECV_WAIT wins over a buffered word, which stays in the buffer
    assign w_consume = w_rx_full &&
                       ((w_accept && (w_op == OP_RECV)) ||
                        ((r_state == c_ST_RECV_WAIT) && !bus.uii_abort));

    trinity_rx_buf #(
        .WIDTH (WIDTH)
    ) u_rx_buf (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .i_data    (bus.uii_link_in),
        .i_capture (bus.uii_link_in_valid),
        .i_consume (w_consume),
        .o_full    (w_rx_full),
        .o_data    (w_rx_data)
    );

    // Next-state decode: only SEND and an unsatisfied RECV leave IDLE
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        case (r_state)
            c_ST_SEND_WAIT: begin
                if (!bus.uii_link_out_ready && !bus.uii_abort) begin
                    w_state_nxt = c_ST_SEND_WAIT;
                end
            end
            c_ST_RECV_WAIT: begin
                if (!bus.uii_abort && !w_rx_full) begin
                    w_state_nxt = c_ST_RECV_WAIT;
                end
            end
            default: begin
                if (w_accept && (w_op == OP_SEND)) begin
                    w_state_nxt = c_ST_SEND_WAIT;
                end else if (w_accept && (w_op == OP_RECV) && !w_rx_full) begin
                    w_state_nxt = c_ST_RECV_WAIT;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator and carry; untouched in SEND_WAIT so the outbound word is stable
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (w_consume) begin
            r_acc <= w_rx_data;
        end else if (w_accept) begin
            case (w_op)
                OP_LOAD: begin
                    r_acc   <= bus.uii_in;
                    r_carry <= 1'b0;
                end
                OP_ADD: begin
                    r_acc   <= w_sum[WIDTH-1:0];
                    r_carry <= w_sum[WIDTH];
                end
                OP_FETCH: begin
                    r_acc <= r_mem[w_addr];
                end
                OP_CLR: begin
                    r_acc   <= '0;
                    r_carry <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Local memory; reset clears every entry
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && (w_op == OP_STORE)) begin
            r_mem[w_addr] <= r_acc;
        end
    end

    assign bus.uii_cmd_ready      = w_idle;
    assign bus.uii_out            = r_acc;
    assign bus.uii_status         = {r_state, r_carry, w_rx_full};
    assign bus.uii_link_in_ready  = !w_rx_full;
    assign bus.uii_link_out       = w_sending ? r_acc : '0;
    assign bus.uii_link_out_valid = w_sending;
    assign bus.uii_link_oe        = {WIDTH{w_sending}};

endmodule
`default_nettype wire

// File: doc/trinity_tile_v2.md
# trinity_tile_v2

Parametrised second-generation Trinity tile: a single-issue accumulator tile with a WIDTH-bit datapath, a DEPTH-entry local memory, and a valid/ready link port toward neighbouring tiles. A small command FSM replaces the fixed mode broadcaster. Commands arrive over a handshaked command port, execute against the accumulator and memory, and can block on link transmit or receive. It sits where the first-generation tile top sat, with uii_out driving the pad-side output.

## Interface
- WIDTH, 8: datapath, memory word and link width; ≥4.
- DEPTH, 4: memory entries; power of two, ≥2. AW = clog2(DEPTH).
- sys_clk  in  1  single clock; all state on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- uii_in  in  WIDTH  command operand; memory address taken from uii_in[AW-1:0].
- uii_cmd  in  3  opcode.
- uii_cmd_valid  in  1  command offered.
- uii_cmd_ready  out  1  tile accepts command; high only in IDLE.
- uii_abort  in  1  forces the FSM to IDLE from any wait state.
- uii_out  out  WIDTH  accumulator value.
- uii_status  out  4  {state[1:0], carry, rx_full}.
- uii_link_in  in  WIDTH  inbound link data.
- uii_link_in_valid  in  1  inbound word offered.
- uii_link_in_ready  out  1  equals !rx_full.
- uii_link_out  out  WIDTH  outbound data; holds acc while sending, else 0.
- uii_link_out_valid  out  1  outbound word offered.
- uii_link_out_ready  in  1  neighbour accepts.
- uii_link_oe  out  WIDTH  all ones while uii_link_out_valid, else all zeros.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LOAD: acc←uii_in, carry←0.
  - 2 ADD: {carry,acc}←acc+uii_in, with a WIDTH+1 sum that wraps modulo 2^WIDTH.
  - 3 STORE: mem[addr]←acc.
  - 4 FETCH: acc←mem[addr].
  - 5 CLR: acc←0, carry←0.
  - 6 SEND.
  - 7 RECV.
- FSM states are IDLE=0, SEND_WAIT=1, RECV_WAIT=2; encoding 3 is unused and maps to IDLE.
- A command is accepted on an edge where uii_cmd_valid && uii_cmd_ready.
- Opcodes 0–5 complete on the accept edge. The FSM stays in IDLE and back-to-back commands are accepted every cycle.
- SEND: IDLE→SEND_WAIT. The value sent is acc at the accept edge; acc cannot change while waiting. Leave to IDLE on the edge where uii_link_out_ready is high.
- RECV:
  - If rx_full at the accept edge: acc←rx_data, rx_full←0, stay in IDLE.
  - Otherwise go to RECV_WAIT. On the first edge with rx_full=1, consume (acc←rx_data, rx_full←0) and go to IDLE.
- Receive buffer: one entry. It captures uii_link_in on an edge where valid && !rx_full. There is no bypass, so a word arriving during RECV_WAIT is consumed one cycle after capture.
- Abort: uii_abort in SEND_WAIT or RECV_WAIT returns the FSM to IDLE with no handshake.
  - If uii_link_out_ready is high on the same edge, the send completes normally.
  - acc, carry and memory are unchanged; a buffered rx word is retained.
  - Abort in IDLE has no effect.
- FETCH/STORE address uses uii_in[AW-1:0]; upper bits are ignored.

## Timing
- Reset values:
  - acc=0, carry=0, all mem=0, rx_full=0, rx_data=0, state=IDLE.
  - uii_cmd_ready=1, uii_link_out=0, uii_link_out_valid=0, uii_link_oe=0, uii_link_in_ready=1, uii_status=0.
- All outputs are registered state or direct decodes of state. uii_out updates the cycle after the accept edge.
- Minimum SEND latency is 1 cycle (valid asserted the cycle after accept); there is no upper bound without abort.
- Minimum RECV latency is 0 extra cycles if rx_full, else 2 cycles after the inbound word is offered.
- uii_link_out_valid, once high, stays high with stable data until the ready handshake or abort.
- Reset asserted mid-operation clears everything immediately, including the in-flight link word.

## Structure
- trinity_pkg holds: the opcode enum (NOP..RECV), the state enum (IDLE, SEND_WAIT, RECV_WAIT), and STATUS_W=4.
- One sub-module, trinity_rx_buf: a one-entry, parametrised-WIDTH receive holding register with a capture/consume interface and a full flag.
- Memory is a register array (DEPTH×WIDTH), with reset clearing all entries.

## Test plan
- Reset, then LOAD 0xF0 and ADD 0x20 (WIDTH=8) → uii_out=0x10, carry=1. CLR → 0x00, carry=0.
- STORE to addresses 0–3 with distinct values, LOAD 0, then FETCH 2 → uii_out equals the stored value. An address of 0x06 (DEPTH=4) aliases to 2.
- SEND with acc=0x5A and link ready held low for 5 cycles:
  - valid, oe=0xFF and data 0x5A stay stable and cmd_ready=0.
  - Raising ready completes the send and IDLE resumes the next cycle.
- RECV while the buffer is empty, then inbound 0x3C offered → link_in_ready drops the next cycle, acc=0x3C one cycle later, FSM returns to IDLE.
- Inbound word buffered before RECV → RECV completes on the accept edge. A second inbound word is held off until consumption.
- Abort in RECV_WAIT, then reset asserted during SEND_WAIT:
  - After the abort: IDLE, acc unchanged.
  - After the reset: all outputs at their reset values asynchronously.
